icache: RTL

- Direct-mapped, one-word-per-block instruction cache between the pipeline's fetch port (imemREN/imemaddr -> ihit/imemload) and the memory controller's instruction port (iREN/iaddr <- iwait/iload).
- Hits are served combinationally in the same cycle.
- Misses run a two-state refill FSM against memory, with the returned word forwarded to fetch on the fill cycle.
- Read-only: no write path and no coherence.

---
 rtl/icache.sv | 99 +++++++++
 1 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-block instruction cache
// Hits are served combinationally; misses run a two-state refill that forwards the fill word to fetch.
module icache #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [31:0]       imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [31:0]       iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, next_state;
  logic [31:2]       miss_addr;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [WORD_W-1:0] data [SETS];

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic              hit, fill, miss;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];

  assign hit  = imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
  assign miss = (state == IDLE) && imemREN && !hit;
  assign fill = (state == FETCH) && !iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
    end else begin
      state <= next_state;
      if (miss)
        miss_addr <= imemaddr[31:2];
      if (fill)
        valid[miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= iload;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = FETCH;
      FETCH:   if (!iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data[req_idx];
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_addr, 2'b00};
        // Forward only if fetch is still asking for the word being filled.
        if (!iwait && imemREN && (imemaddr[31:2] == miss_addr)) begin
          ihit     = 1'b1;
          imemload = iload;
        end
      end
      default: ;
    endcase
  end

endmodule
